br_resolve: RTL and testbench
=============================

# br_resolve

Decode-stage branch resolver with a parametrised branch history table (BHT) of 2-bit saturating counters. It decodes all MIPS-I control transfers, including the REGIMM and sign-test branches and the link forms. It resolves each branch against the prediction fetch made, and issues a registered one-cycle redirect plus link writeback information. It sits between IF and ID: IF reads predictions through a lookup port, and ID feeds decoded instructions and register operands.

## Interface
- `XLEN`, 32: datapath width.
- `BHT_ENTRIES`, 64: counter count; power of two, 2..1024.
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `if_pc`  in  XLEN: fetch PC for prediction lookup.
- `if_pred`  out  1: predict-taken for `if_pc`; combinational read of table state.
- `id_valid`  in  1: ID holds a valid instruction.
- `id_stall`  in  1: ID held this cycle; no resolution.
- `id_ir`  in  32: instruction word.
- `id_pc`  in  XLEN: branch address + 4 (delay-slot PC).
- `id_pred`  in  1: `if_pred` value captured at fetch of this instruction.
- `reg_a`, `reg_b`  in  XLEN: rs and rt operands.
- `redirect`  out  1: one-cycle pulse; fetch must restart at `redirect_addr`.
- `redirect_addr`  out  XLEN: restart address.
- `link_we`  out  1: write `link_data` to `link_reg`.
- `link_reg`  out  5: destination register.
- `link_data`  out  XLEN: `id_pc + 4`.

## Operation
- Decode:
  - beq 000100, bne 000101, blez 000110, bgtz 000111.
  - REGIMM 000001 with rt 00000 bltz, 00001 bgez, 10000 bltzal, 10001 bgezal.
  - j 000010, jal 000011.
  - SPECIAL with funct 001000 jr, 001001 jalr.
  - Any other encoding is not a branch and produces no output.
- Conditions:
  - beq/bne use `reg_a == reg_b`.
  - Sign tests are signed on `reg_a`.
- Targets:
  - Conditional branches: `id_pc + (sext(imm16) << 2)`, XLEN-wrapping add.
  - j/jal: `{id_pc[XLEN-1:28], ir[25:0], 2'b00}`.
  - jr/jalr: `reg_a`, unmodified.
- Redirect:
  - Conditional, actual taken and `id_pred` = 0: redirect to target.
  - Conditional, actual not taken and `id_pred` = 1: redirect to `id_pc + 4`.
  - Conditional, actual equals `id_pred`: no redirect.
  - Unconditional forms always redirect.
- Link:
  - jal, bltzal and bgezal write register 31.
  - jalr writes `ir[15:11]`.
  - Link forms write regardless of whether the branch is taken.
- BHT:
  - Index is `pc[log2(BHT_ENTRIES)+1:2]`.
  - Lookup uses `if_pc`; update uses `id_pc - 4`.
  - Predict taken when counter bit 1 = 1.
  - Only conditional branches update: taken increments, not taken decrements, saturating at 00/11.
  - Unconditional forms never touch the table.
- Fetch computes predicted-taken targets itself from the instruction word; this block supplies only the prediction bit.

## Timing
- Resolution occurs when `id_valid & !id_stall`. Results are registered and appear on outputs the following cycle; latency is 1.
- Output registers load every cycle: the resolution result if resolving, else zero. `redirect` and `link_we` are therefore single-cycle pulses and never repeat during stalls.
- The BHT update takes effect at the same edge as the output register load. An `if_pc` lookup of the same entry in that cycle returns the old counter; the new value is visible the next cycle.
- Reset:
  - `redirect`, `link_we`, `redirect_addr`, `link_reg` and `link_data` clear to 0.
  - Every counter is set to 01 (weakly not-taken).
  - Reset asserted mid-resolution discards the pending result.
- Branch in a delay slot: resolved as normal, with no special handling.

## Configuration
- `BR_RESOLVE_BHT_EN` defined: the BHT is present as described.
- Undefined:
  - No table storage.
  - `if_pred` is tied 0 and `id_pred` is ignored (treated as 0).
  - Every taken conditional redirects; not-taken never redirects.

## Structure
- A shared `mips_pkg` holds:
  - opcode, REGIMM rt and funct constants;
  - the 2-bit counter reset value (01);
  - the branch-kind enum: NONE, COND, JUMP, JREG.
- One sub-module, `bht_2bit`: one read port, one write port, saturating update, asynchronous reset. It is instantiated only under `BR_RESOLVE_BHT_EN`.

## Test plan
- Reset, then `if_pc` = 0x100 → `if_pred` = 0, and all outputs are 0 after reset.
- beq, offset +4, `id_pc` 0x104, `reg_a` = `reg_b` = 5, `id_pred` 0 → next cycle `redirect` = 1 with `redirect_addr` = 0x114; the counter at index 0 becomes 10.
- Same beq again with `id_pred` 1 → no redirect; counter goes to 11, and `if_pc` 0x100 then yields `if_pred` = 1.
- bgez, `reg_a` 0x80000000, `id_pred` 1 → `redirect_addr` = `id_pc + 4`.
- bltzal, `reg_a` 0 → `link_we` = 1, `link_reg` = 31, `link_data` = `id_pc + 4`, no redirect. jalr rd=7 → `link_reg` 7 and `redirect_addr` = `reg_a`.
- jal with `id_stall` held 3 cycles → no outputs while stalled, exactly one redirect pulse after `id_stall` drops. Reset asserted on the resolve edge → no pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_pkg                                                                 |
// | Shared MIPS-I control-transfer encodings, branch kinds, counter helpers. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] c_op_special = 6'b000000;
  localparam logic [5:0] c_op_regimm  = 6'b000001;
  localparam logic [5:0] c_op_j       = 6'b000010;
  localparam logic [5:0] c_op_jal     = 6'b000011;
  localparam logic [5:0] c_op_beq     = 6'b000100;
  localparam logic [5:0] c_op_bne     = 6'b000101;
  localparam logic [5:0] c_op_blez    = 6'b000110;
  localparam logic [5:0] c_op_bgtz    = 6'b000111;

  // REGIMM sub-opcodes carried in the rt field (ir[20:16])
  localparam logic [4:0] c_rt_bltz   = 5'b00000;
  localparam logic [4:0] c_rt_bgez   = 5'b00001;
  localparam logic [4:0] c_rt_bltzal = 5'b10000;
  localparam logic [4:0] c_rt_bgezal = 5'b10001;

  // SPECIAL function codes (ir[5:0])
  localparam logic [5:0] c_fn_jr   = 6'b001000;
  localparam logic [5:0] c_fn_jalr = 6'b001001;

  localparam logic [4:0] c_link_ra   = 5'd31;
  localparam logic [1:0] c_ctr_reset = 2'b01;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    COND = 2'd1,
    JUMP = 2'd2,
    JREG = 2'd3
  } br_kind_e;

  // Two-bit saturating counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != 2'b11)) begin
      nxt = ctr + 2'b01;
    end else if (!taken && (ctr != 2'b00)) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bht_2bit.sv
// +--------------------------------------------------------------------------+
// | bht_2bit                                                                 |
// | Table of 2-bit saturating counters: one async read, one update port.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bht_2bit
  import mips_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] r_ctr [ENTRIES];

  // Reads see the pre-update value during the update cycle.
  assign rd_ctr = r_ctr[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= c_ctr_reset;
      end
    end else if (wr_en) begin
      r_ctr[wr_idx] <= ctr_next(r_ctr[wr_idx], wr_taken);
    end
  end

endmodule

`default_nettype wire

// File: rtl/br_resolve.sv
// +--------------------------------------------------------------------------+
// | br_resolve                                                               |
// | Decode-stage MIPS-I branch resolver with registered redirect and link.   |
// | Optional branch history table enabled by macro BR_RESOLVE_BHT_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module br_resolve
  import mips_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred,
  input  logic            id_valid,
  input  logic            id_stall,
  input  logic [31:0]     id_ir,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_pred,
  input  logic [XLEN-1:0] reg_a,
  input  logic [XLEN-1:0] reg_b,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_addr,
  output logic            link_we,
  output logic [4:0]      link_reg,
  output logic [XLEN-1:0] link_data
);

  logic [5:0]      w_op;
  logic [4:0]      w_rt;
  logic [5:0]      w_fn;
  logic            w_eq;
  logic            w_neg;
  logic            w_zero;
  br_kind_e        w_kind;
  logic            w_taken;
  logic            w_link;
  logic [4:0]      w_link_reg;
  logic            w_pred;
  logic            w_resolve;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_j_target;
  logic            w_redirect;
  logic [XLEN-1:0] w_redirect_addr;

  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_addr;
  logic            r_link_we;
  logic [4:0]      r_link_reg;
  logic [XLEN-1:0] r_link_data;

  assign w_op   = id_ir[31:26];
  assign w_rt   = id_ir[20:16];
  assign w_fn   = id_ir[5:0];
  assign w_eq   = (reg_a == reg_b);
  assign w_neg  = reg_a[XLEN-1];
  assign w_zero = (reg_a == '0);

  assign w_resolve   = id_valid & ~id_stall;
  assign w_seq_pc    = id_pc + XLEN'(4);
  assign w_br_target = id_pc + {{(XLEN-18){id_ir[15]}}, id_ir[15:0], 2'b00};
  assign w_j_target  = {id_pc[XLEN-1:28], id_ir[25:0], 2'b00};

  always_comb begin
    w_kind     = NONE;
    w_taken    = 1'b0;
    w_link     = 1'b0;
    w_link_reg = '0;
    case (w_op)
      c_op_beq:  begin w_kind = COND; w_taken = w_eq;              end
      c_op_bne:  begin w_kind = COND; w_taken = ~w_eq;             end
      c_op_blez: begin w_kind = COND; w_taken = w_neg | w_zero;    end
      c_op_bgtz: begin w_kind = COND; w_taken = ~w_neg & ~w_zero;  end
      c_op_regimm: begin
        case (w_rt)
          c_rt_bltz: begin w_kind = COND; w_taken = w_neg;  end
          c_rt_bgez: begin w_kind = COND; w_taken = ~w_neg; end
          c_rt_bltzal: begin
            w_kind     = COND;
            w_taken    = w_neg;
            w_link     = 1'b1;
            w_link_reg = c_link_ra;
          end
          c_rt_bgezal: begin
            w_kind     = COND;
            w_taken    = ~w_neg;
            w_link     = 1'b1;
            w_link_reg = c_link_ra;
          end
          default: ;
        endcase
      end
      c_op_j: begin
        w_kind = JUMP;
      end
      c_op_jal: begin
        w_kind     = JUMP;
        w_link     = 1'b1;
        w_link_reg = c_link_ra;
      end
      c_op_special: begin
        if (w_fn == c_fn_jr) begin
          w_kind = JREG;
        end else if (w_fn == c_fn_jalr) begin
          w_kind     = JREG;
          w_link     = 1'b1;
          w_link_reg = id_ir[15:11];
        end
      end
      default: ;
    endcase
  end

  // A conditional branch only redirects when fetch guessed wrong.
  always_comb begin
    w_redirect      = 1'b0;
    w_redirect_addr = '0;
    case (w_kind)
      COND: begin
        if (w_taken != w_pred) begin
          w_redirect      = 1'b1;
          w_redirect_addr = w_taken ? w_br_target : w_seq_pc;
        end
      end
      JUMP: begin
        w_redirect      = 1'b1;
        w_redirect_addr = w_j_target;
      end
      JREG: begin
        w_redirect      = 1'b1;
        w_redirect_addr = reg_a;
      end
      default: ;
    endcase
  end

`ifdef BR_RESOLVE_BHT_EN
  localparam int c_idx_w = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0] w_upd_pc;
  logic [1:0]      w_rd_ctr;
  logic            w_bht_we;
  logic            w_unused_bits;

  // id_pc is the delay-slot PC; the table is keyed by the branch itself.
  assign w_upd_pc = id_pc - XLEN'(4);
  assign w_bht_we = w_resolve & (w_kind == COND);

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (c_idx_w)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[c_idx_w+1:2]),
    .rd_ctr   (w_rd_ctr),
    .wr_en    (w_bht_we),
    .wr_idx   (w_upd_pc[c_idx_w+1:2]),
    .wr_taken (w_taken)
  );

  assign if_pred       = w_rd_ctr[1];
  assign w_pred        = id_pred;
  assign w_unused_bits = ^{if_pc, w_upd_pc, w_rd_ctr};
`else
  localparam int c_unused_entries = BHT_ENTRIES;

  logic w_unused_bits;

  assign if_pred       = 1'b0;
  assign w_pred        = 1'b0;
  assign w_unused_bits = ^{if_pc, id_pred};
`endif

  // Outputs reload every cycle so pulses never repeat across stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect      <= 1'b0;
      r_redirect_addr <= '0;
      r_link_we       <= 1'b0;
      r_link_reg      <= '0;
      r_link_data     <= '0;
    end else begin
      r_redirect      <= w_resolve & w_redirect;
      r_redirect_addr <= (w_resolve & w_redirect) ? w_redirect_addr : '0;
      r_link_we       <= w_resolve & w_link;
      r_link_reg      <= (w_resolve & w_link) ? w_link_reg : '0;
      r_link_data     <= (w_resolve & w_link) ? w_seq_pc : '0;
    end
  end

  assign redirect      = r_redirect;
  assign redirect_addr = r_redirect_addr;
  assign link_we       = r_link_we;
  assign link_reg      = r_link_reg;
  assign link_data     = r_link_data;

endmodule

`default_nettype wire

// File: tb/tb_br_resolve.sv
// +--------------------------------------------------------------------------+
// | tb_br_resolve                                                            |
// | Self-checking bench for br_resolve with an architectural branch model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_br_resolve;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred;
  logic        id_valid;
  logic        id_stall;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic        id_pred;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        link_we;
  logic [4:0]  link_reg;
  logic [31:0] link_data;

  int checks = 0;
  int errors = 0;
  bit run    = 0;

  int          m_ctr [ENTRIES];
  logic        m_redirect;
  logic [31:0] m_addr;
  logic        m_link_we;
  logic [4:0]  m_lreg;
  logic [31:0] m_ldata;

  br_resolve #(.XLEN(XLEN), .BHT_ENTRIES(ENTRIES)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_pred       (if_pred),
    .id_valid      (id_valid),
    .id_stall      (id_stall),
    .id_ir         (id_ir),
    .id_pc         (id_pc),
    .id_pred       (id_pred),
    .reg_a         (reg_a),
    .reg_b         (reg_b),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .link_we       (link_we),
    .link_reg      (link_reg),
    .link_data     (link_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic int tbl_idx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(ENTRIES));
  endfunction

  function automatic logic exp_pred(input logic [31:0] pc);
`ifdef BR_RESOLVE_BHT_EN
    return m_ctr[tbl_idx(pc)] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  // Architectural model: what the instruction means, not how the RTL decodes it.
  always @(posedge clk or posedge rst) begin : model
    bit          cond, uncond, tk, lnk, pred;
    logic [31:0] tgt;
    logic [4:0]  lr;
    int          ix;
    m_redirect = 1'b0; m_addr = '0; m_link_we = 1'b0; m_lreg = '0; m_ldata = '0;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
    end else if (id_valid && !id_stall) begin
      cond = 0; uncond = 0; tk = 0; lnk = 0; lr = 5'd31;
      tgt = id_pc + 32'($signed(id_ir[15:0])) * 4;
      case (id_ir[31:26])
        6'h04: begin cond = 1; tk = (reg_a == reg_b); end
        6'h05: begin cond = 1; tk = (reg_a != reg_b); end
        6'h06: begin cond = 1; tk = ($signed(reg_a) <= 0); end
        6'h07: begin cond = 1; tk = ($signed(reg_a) > 0); end
        6'h01: begin
          case (id_ir[20:16])
            5'h00: begin cond = 1; tk = ($signed(reg_a) < 0); end
            5'h01: begin cond = 1; tk = ($signed(reg_a) >= 0); end
            5'h10: begin cond = 1; tk = ($signed(reg_a) < 0); lnk = 1; end
            5'h11: begin cond = 1; tk = ($signed(reg_a) >= 0); lnk = 1; end
            default: ;
          endcase
        end
        6'h02: begin uncond = 1; tgt = {id_pc[31:28], id_ir[25:0], 2'b00}; end
        6'h03: begin uncond = 1; lnk = 1; tgt = {id_pc[31:28], id_ir[25:0], 2'b00}; end
        6'h00: begin
          if (id_ir[5:0] == 6'h08) begin uncond = 1; tgt = reg_a; end
          if (id_ir[5:0] == 6'h09) begin uncond = 1; tgt = reg_a; lnk = 1; lr = id_ir[15:11]; end
        end
        default: ;
      endcase
`ifdef BR_RESOLVE_BHT_EN
      pred = id_pred;
`else
      pred = 1'b0;
`endif
      if (cond) begin
        if (tk != pred) begin
          m_redirect = 1'b1;
          m_addr     = tk ? tgt : id_pc + 32'd4;
        end
        ix = tbl_idx(id_pc - 32'd4);
        if (tk) m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
        else    m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
      end
      if (uncond) begin
        m_redirect = 1'b1;
        m_addr     = tgt;
      end
      if (lnk) begin
        m_link_we = 1'b1;
        m_lreg    = lr;
        m_ldata   = id_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("cmp_redirect", {31'b0, redirect}, {31'b0, m_redirect});
      chk("cmp_link_we", {31'b0, link_we}, {31'b0, m_link_we});
      if (m_redirect) chk("cmp_redirect_addr", redirect_addr, m_addr);
      if (m_link_we) begin
        chk("cmp_link_reg", {27'b0, link_reg}, {27'b0, m_lreg});
        chk("cmp_link_data", link_data, m_ldata);
      end
      chk("cmp_if_pred", {31'b0, if_pred}, {31'b0, exp_pred(if_pc)});
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic resolve(input logic [31:0] ir, input logic [31:0] pc, input logic pred,
                         input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1; id_stall = 1'b0; id_ir = ir; id_pc = pc; id_pred = pred;
    reg_a = a; reg_b = b; if_pc = pc - 32'd4;
    tick();
    id_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{32'h1422FFFC, 32'h0000_0008, 1'b0, 32'd1,         32'd2};  // bne taken, wraps below 0
    vecs[1] = '{32'h1820_0005, 32'h0000_1000, 1'b0, 32'd0,        32'd0};  // blez on zero
    vecs[2] = '{32'h1C20_0005, 32'h0000_1000, 1'b1, 32'd0,        32'd0};  // bgtz on zero
    vecs[3] = '{32'h0420_0003, 32'h0000_2000, 1'b0, 32'hFFFF_FFFF, 32'd0}; // bltz
    vecs[4] = '{32'h0431_0002, 32'h0000_2100, 1'b0, 32'd5,        32'd0};  // bgezal
    vecs[5] = '{32'h0800_0040, 32'hA000_0000, 1'b0, 32'd0,        32'd0};  // j
    vecs[6] = '{32'h0020_0008, 32'h0000_3000, 1'b1, 32'hDEAD_BEE0, 32'd0}; // jr
    vecs[7] = '{32'h2421_0001, 32'h0000_3100, 1'b1, 32'd0,        32'd0};  // addiu
    vecs[8] = '{32'h0022_1820, 32'h0000_3200, 1'b0, 32'd0,        32'd0};  // add
    vecs[9] = '{32'h0422_0001, 32'h0000_3300, 1'b0, 32'd0,        32'd0};  // REGIMM unused rt
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_stall = 1'b0; id_ir = '0; id_pc = '0;
    id_pred = 1'b0; reg_a = '0; reg_b = '0; if_pc = 32'h100;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    run = 1'b1;
    tick();

    chk("reset_if_pred", {31'b0, if_pred}, 32'd0);
    chk("reset_redirect", {31'b0, redirect}, 32'd0);
    chk("reset_link_we", {31'b0, link_we}, 32'd0);
    chk("reset_redirect_addr", redirect_addr, 32'd0);
    chk("reset_link_reg", {27'b0, link_reg}, 32'd0);
    chk("reset_link_data", link_data, 32'd0);

    resolve(32'h1022_0004, 32'h104, 1'b0, 32'd5, 32'd5);
    chk("beq1_redirect", {31'b0, redirect}, 32'd1);
    chk("beq1_addr", redirect_addr, 32'h114);
`ifdef BR_RESOLVE_BHT_EN
    chk("beq1_if_pred", {31'b0, if_pred}, 32'd1);
`endif

    resolve(32'h1022_0004, 32'h104, 1'b1, 32'd5, 32'd5);
`ifdef BR_RESOLVE_BHT_EN
    chk("beq2_redirect", {31'b0, redirect}, 32'd0);
    chk("beq2_if_pred", {31'b0, if_pred}, 32'd1);
`else
    chk("beq2_redirect", {31'b0, redirect}, 32'd1);
    chk("beq2_addr", redirect_addr, 32'h114);
    chk("beq2_if_pred", {31'b0, if_pred}, 32'd0);
`endif

    resolve(32'h0461_0010, 32'h200, 1'b1, 32'h8000_0000, 32'd0);
`ifdef BR_RESOLVE_BHT_EN
    chk("bgez_redirect", {31'b0, redirect}, 32'd1);
    chk("bgez_addr", redirect_addr, 32'h204);
`else
    chk("bgez_redirect", {31'b0, redirect}, 32'd0);
`endif

    resolve(32'h0470_0008, 32'h300, 1'b0, 32'd0, 32'd0);
    chk("bltzal_link_we", {31'b0, link_we}, 32'd1);
    chk("bltzal_link_reg", {27'b0, link_reg}, 32'd31);
    chk("bltzal_link_data", link_data, 32'h304);
    chk("bltzal_redirect", {31'b0, redirect}, 32'd0);

    resolve(32'h0080_3809, 32'h400, 1'b0, 32'h1234_5678, 32'd0);
    chk("jalr_redirect", {31'b0, redirect}, 32'd1);
    chk("jalr_addr", redirect_addr, 32'h1234_5678);
    chk("jalr_link_reg", {27'b0, link_reg}, 32'd7);
    chk("jalr_link_data", link_data, 32'h404);

    for (int i = 0; i < 10; i++) begin
      resolve(vecs[i].ir, vecs[i].pc, vecs[i].pred, vecs[i].a, vecs[i].b);
    end

    // Drive entry 0 down past the floor, then back up one step at a time.
    for (int i = 0; i < 4; i++) begin
      resolve(32'h1022_0004, 32'h104, 1'b1, 32'd1, 32'd2);
    end
    resolve(32'h1022_0004, 32'h104, 1'b0, 32'd3, 32'd3);
    chk("sat_low_if_pred", {31'b0, if_pred}, 32'd0);
    resolve(32'h1022_0004, 32'h104, 1'b0, 32'd3, 32'd3);
`ifdef BR_RESOLVE_BHT_EN
    chk("sat_up_if_pred", {31'b0, if_pred}, 32'd1);
`else
    chk("sat_up_if_pred", {31'b0, if_pred}, 32'd0);
`endif

    id_valid = 1'b1; id_stall = 1'b1; id_ir = 32'h0C00_0100; id_pc = 32'h5000_0010;
    id_pred = 1'b0; reg_a = '0; reg_b = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_redirect", {31'b0, redirect}, 32'd0);
      chk("stall_link_we", {31'b0, link_we}, 32'd0);
    end
    id_stall = 1'b0;
    tick();
    id_valid = 1'b0;
    chk("jal_redirect", {31'b0, redirect}, 32'd1);
    chk("jal_addr", redirect_addr, 32'h5000_0400);
    chk("jal_link_reg", {27'b0, link_reg}, 32'd31);
    chk("jal_link_data", link_data, 32'h5000_0014);
    tick();
    chk("jal_no_repeat", {31'b0, redirect}, 32'd0);

    id_valid = 1'b1; id_stall = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    chk("rst_edge_redirect", {31'b0, redirect}, 32'd0);
    chk("rst_edge_link_we", {31'b0, link_we}, 32'd0);
    id_valid = 1'b0;
    rst = 1'b0;
    if_pc = 32'h100;
    tick();
    chk("post_rst_redirect", {31'b0, redirect}, 32'd0);
    chk("post_rst_if_pred", {31'b0, if_pred}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
